// File: rtl/sram512x8_port.sv
// sram512x8_port
//   Valid/ready front-end for a single-port SRAM macro with a registered
//   read output (SRAM1RW512x8). Each accepted request becomes one macro
//   operation in the same cycle. Reads return data one cycle later on the
//   response channel. A 2-entry skid FIFO absorbs response backpressure.
//
//   Optional feature macro: SRAM_PORT_INIT_EN
//     When defined, the block zero-fills the whole array after every reset,
//     one word per cycle, before it accepts requests.
//
// Ports
//   clk, rst_n            clock (also macro CE), async active-low reset
//   req_valid/req_ready   request handshake
//   req_we/addr/wdata     request payload (we=1 write, 0 read)
//   rsp_valid/rsp_ready   response handshake (reads only)
//   rsp_rdata             read data
//   sram_csb/web/oeb      macro strobes, active low
//   sram_a, sram_i        macro address / write data
//   sram_o                macro registered read data
module sram512x8_port #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_i,
   input  logic [DATA_W-1:0] sram_o
);

   logic                   running;   // accepting requests this cycle
   logic                   acc;
   logic                   rd_pend;   // sram_o carries read data this cycle
   logic [1:0]             cnt;       // skid FIFO occupancy
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic [1:0][DATA_W-1:0] fifo_q;
   logic                   push;
   logic                   pop;

`ifdef SRAM_PORT_INIT_EN
   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] init_addr;
   logic              init_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         init_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_INIT) init_addr <= init_addr + 1'b1;
      end
   end

   // rst_n gates the strobes so nothing reaches the macro while in reset.
   always_comb begin
      state_nxt = state;
      init_wr   = 1'b0;
      running   = 1'b0;
      case (state)
         S_INIT: begin
            init_wr = rst_n;
            if (init_addr == {ADDR_W{1'b1}}) state_nxt = S_RUN;
         end
         S_RUN:   running = rst_n;
         default: state_nxt = S_INIT;
      endcase
   end

   assign sram_csb = ~(acc | init_wr);
   assign sram_web = ~((acc & req_we) | init_wr);
   assign sram_oeb = ~(acc & ~req_we);
   assign sram_a   = init_wr ? init_addr : req_addr;
   assign sram_i   = init_wr ? '0 : req_wdata;
`else
   // Combinational rst_n term keeps req_ready (and so every strobe) low
   // while reset is held, and lets the block run from the first cycle after.
   assign running  = rst_n;

   assign sram_csb = ~acc;
   assign sram_web = ~(acc & req_we);
   assign sram_oeb = ~(acc & ~req_we);
   assign sram_a   = req_addr;
   assign sram_i   = req_wdata;
`endif

   // Count the in-flight read in rd_pend so the FIFO can never overflow;
   // req_ready depends only on state, never on rsp_ready.
   assign req_ready = running & ((cnt + {1'b0, rd_pend}) < 2'd2);
   assign acc       = req_valid & req_ready;

   // Empty FIFO: present the macro output directly (bypass).
   assign rsp_valid = rd_pend | (cnt != 2'd0);
   assign rsp_rdata = (cnt == 2'd0) ? sram_o : fifo_q[rd_ptr];

   assign pop  = (cnt != 2'd0) & rsp_ready;
   // Macro data must be captured unless it left through the bypass.
   assign push = rd_pend & ((cnt != 2'd0) | ~rsp_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend <= 1'b0;
         cnt     <= 2'd0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
      end else begin
         rd_pend <= acc & ~req_we;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr] <= sram_o;
   end

endmodule

// File: tb/tb_sram512x8_port.sv
module tb_sram512x8_port;

   localparam int DEPTH = 512;
`ifdef SRAM_PORT_INIT_EN
   localparam int INIT_CYC = DEPTH;
`else
   localparam int INIT_CYC = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
   logic [8:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       req_ready, rsp_valid;
   logic [7:0] rsp_rdata;
   logic       sram_csb, sram_web, sram_oeb;
   logic [8:0] sram_a;
   logic [7:0] sram_i;
   logic [7:0] sram_o = '0;

   int n_chk = 0, n_pass = 0, stalls = 0;

   sram512x8_port #(.ADDR_W(9), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
      .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
   );

   always #5 clk = ~clk;

   // Macro: synchronous write, registered read.
   logic [7:0] smem [DEPTH];
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) smem[sram_a] <= sram_i;
         if (!sram_oeb) sram_o <= smem[sram_a];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Behavioural model: memory contents plus the queue of read results not
   // yet handed over. A read accepted at an edge is visible right after it.
   logic [7:0] mem_m [DEPTH];
   logic [7:0] avail [$];
   logic [7:0] got [$];
   int         init_left = INIT_CYC;

   always @(negedge rst_n) begin
      avail.delete();
      init_left = INIT_CYC;
   end

   always @(negedge clk) begin
      logic exp_rdy, acc_m;
      if (!rst_n) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_pins", {sram_csb, sram_web, sram_oeb}, 3'b111);
      end else begin
         exp_rdy = (init_left == 0) && (avail.size() < 2);
         chk("req_ready", req_ready, exp_rdy);
         chk("rsp_valid", rsp_valid, avail.size() != 0);
         if (avail.size() != 0) chk("rsp_rdata", rsp_rdata, avail[0]);
         if (avail.size() != 0 && rsp_ready) begin
            got.push_back(rsp_rdata);
            void'(avail.pop_front());
         end
         if (init_left > 0) begin
            chk("init_pins", {sram_csb, sram_web, sram_oeb}, 3'b001);
            chk("init_a", sram_a, DEPTH - init_left);
            chk("init_i", sram_i, 0);
            mem_m[DEPTH - init_left] = 8'h00;
            init_left--;
         end else begin
            acc_m = req_valid && exp_rdy;
            chk("pins", {sram_csb, sram_web, sram_oeb},
                {~acc_m, ~(acc_m && req_we), ~(acc_m && !req_we)});
            if (acc_m) begin
               chk("sram_a", sram_a, req_addr);
               if (req_we) begin
                  chk("sram_i", sram_i, req_wdata);
                  mem_m[req_addr] = req_wdata;
               end else begin
                  avail.push_back(mem_m[req_addr]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until it is accepted at a clock edge.
   task automatic issue(input logic we, input logic [8:0] a, input logic [7:0] d);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (req_ready) begin
            tick();
            return;
         end
         stalls++;
         tick();
      end
      n_chk++;
      $display("FAIL issue_timeout: addr %0h never accepted", a);
   endtask

   task automatic idle();
      req_valid = 1'b0;
   endtask

   initial begin
      #1;
      chk("lit_rst_ready", req_ready, 0);
      chk("lit_rst_pins", {sram_csb, sram_web, sram_oeb}, 3'b111);
      repeat (3) tick();
      rst_n = 1'b1;
`ifndef SRAM_PORT_INIT_EN
      @(negedge clk);
      chk("lit_ready_after_rst", req_ready, 1);
      tick();
`endif

      // Write then read, bypass response.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h010; req_wdata = 8'h3A;
      for (int k = 0; k < 2000 && !req_ready; k++) tick();
      @(negedge clk);
      chk("lit_wr_web", sram_web, 0);
      tick();
      issue(1'b0, 9'h010, 8'h00);
      idle();
      @(negedge clk);
      chk("lit_rd_valid", rsp_valid, 1);
      chk("lit_rd_data", rsp_rdata, 8'h3A);
      tick();

`ifdef SRAM_PORT_INIT_EN
      issue(1'b0, 9'h123, 8'h00);
      idle();
      @(negedge clk);
      chk("lit_init_zero", rsp_rdata, 8'h00);
      tick();
`endif

      // Streaming: full write sweep then full read sweep.
      stalls = 0;
      for (int i = 0; i < DEPTH; i++) issue(1'b1, 9'(i), 8'(i));
      got.delete();
      for (int i = 0; i < DEPTH; i++) issue(1'b0, 9'(i), 8'h00);
      idle();
      repeat (2) tick();
      chk("lit_stream_stalls", stalls, 0);
      chk("lit_stream_count", got.size(), DEPTH);
      if (got.size() == DEPTH) begin
         chk("lit_stream_first", got[0], 8'h00);
         chk("lit_stream_mid", got[256], 8'h00);
         chk("lit_stream_last", got[511], 8'hFF);
      end

      // Backpressure: third read held off until the first pop.
      rsp_ready = 1'b0;
      got.delete();
      issue(1'b0, 9'h001, 8'h00);
      issue(1'b0, 9'h002, 8'h00);
      req_addr = 9'h003;
      @(negedge clk);
      chk("lit_bp_hold", req_ready, 0);
      tick();
      @(negedge clk);
      chk("lit_bp_hold2", req_ready, 0);
      chk("lit_bp_valid", rsp_valid, 1);
      tick();
      rsp_ready = 1'b1;
      issue(1'b0, 9'h003, 8'h00);
      idle();
      repeat (4) tick();
      chk("lit_bp_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("lit_bp_d0", got[0], 8'h01);
         chk("lit_bp_d1", got[1], 8'h02);
         chk("lit_bp_d2", got[2], 8'h03);
      end

      // Read-after-write, consecutive cycles.
      issue(1'b1, 9'h1FF, 8'h55);
      issue(1'b0, 9'h1FF, 8'h00);
      idle();
      @(negedge clk);
      chk("lit_raw", rsp_rdata, 8'h55);
      tick();

      // Reset with the FIFO full and a request still presented.
      rsp_ready = 1'b0;
      issue(1'b0, 9'h010, 8'h00);
      issue(1'b0, 9'h1FF, 8'h00);
      tick();
      @(negedge clk);
      chk("lit_pre_rst_valid", rsp_valid, 1);
      chk("lit_pre_rst_ready", req_ready, 0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("lit_async_valid", rsp_valid, 0);
      chk("lit_async_pins", {sram_csb, sram_web, sram_oeb}, 3'b111);
      idle();
      repeat (2) tick();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      issue(1'b0, 9'h1FF, 8'h00);
      idle();
      @(negedge clk);
`ifdef SRAM_PORT_INIT_EN
      chk("lit_post_rst", rsp_rdata, 8'h00);
`else
      chk("lit_post_rst", rsp_rdata, 8'h55);
`endif
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
